score_display: RTL and testbench
================================

// Module: score_display
// PURPOSE
//  Downstream consumer of the playfield/score stage. Takes the 16-bit binary hit score,
//  converts it to five BCD digits with a sequential double-dabble engine, and drives the
//  Nexys4 8-digit multiplexed seven-segment display with leading-zero blanking.
//  Sits between the score register and the board-level an/seg/dp pins.
// PARAMETERS
//  REFRESH_DIV    100000  clk cycles per digit slot (1 ms per digit at 100 MHz)
//  BLANK_LEADING  1       1 = blank leading zeros of the 5-digit value; 0 = show all 5
// PORTS
//  clk       in   1   system clock (100 MHz)
//  reset_n   in   1   asynchronous, active-low reset
//  score     in   16  binary score from the score stage, unsigned
//  an        out  8   digit anodes, active-low, one-hot-low when lit
//  seg       out  7   cathodes {g,f,e,d,c,b,a}, active-low
//  dp        out  1   decimal point, active-low; held 1 (off)
//  busy      out  1   high while a conversion is in flight
// BEHAVIOUR
//  Reset (async, while reset_n=0): an=8'hFF, seg=7'h7F, dp=1, busy=0, state=IDLE,
//   last_score=0, disp_bcd=20'h0, scan index=0, refresh count=0.
//  Converter FSM, states IDLE -> SHIFT -> LATCH -> IDLE:
//   IDLE: if score != last_score, capture score into bin_sr, clear bcd_sr (20 b), cnt=0,
//     busy<=1, go SHIFT. Otherwise stay.
//   SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd_sr,bin_sr} left 1;
//     cnt++; after the 16th shift go LATCH.
//   LATCH: disp_bcd<=bcd_sr, last_score<=captured value, busy<=0, go IDLE.
//   Latency: score change -> disp_bcd update = 18 clks (capture + 16 shifts + latch).
//   score changes during SHIFT/LATCH are ignored; re-compared in IDLE, so the final value
//   always converges to the latest score. Max value 65535 fits 5 digits; no overflow path.
//  Scan: refresh counter 0..REFRESH_DIV-1; on wrap, index = (index+1) mod 8.
//   Digit i (0 = least significant) selects disp_bcd[4i+3:4i] for i<5.
//   Outputs registered: an/seg reflect index one clk after index changes.
//   an[i]=0 iff i==index, i<5, and digit i not blanked; indices 5..7 always dark (an=FF, seg=7F).
//   Blanking (BLANK_LEADING=1): digit i>0 blanked iff digits i..4 all zero; digit 0 never
//   blanked. Blanked digit: an=8'hFF, seg=7'h7F.
//  Seg encoding (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; nibbles A-F unreachable -> 7F.
//  Reset mid-conversion: abort immediately to reset values; after release, a nonzero score
//   triggers a fresh conversion on the first clk.
// STRUCTURE
//  Shared package gh_display_pkg: SEG_0..SEG_9, SEG_OFF constants, converter state encoding
//   (IDLE/SHIFT/LATCH), NUM_BCD_DIGITS=5, NUM_ANODES=8.
//  One sub-module: bin2bcd_seq (start/bin in, done/bcd out, 16-bit -> 20-bit double dabble);
//   scan counter, blanking and seg decode stay in score_display.
// TESTING (bench runs REFRESH_DIV=4 for speed)
//  1 Reset release, score=0 -> busy stays 0; only slot 0 lights: an=8'hFE, seg=7'b1000000.
//  2 score=1234 -> busy=1 next clk for 17 clks; disp_bcd=20'h01234 at clk 18; slots 0..3
//    show 4,3,2,1 (seg 0011001,0110000,0100100,1111001), slot 4 blanked.
//  3 score=65535 -> disp_bcd=20'h65535; all five slots lit; slots 5..7 an=8'hFF.
//  4 score 100 then 200 at clk 5 of conversion -> disp_bcd=20'h00100 latched first, second
//    conversion follows, final disp_bcd=20'h00200, busy low.
//  5 Scan: index advances every 4 clks, wraps 7->0; an never has more than one 0 bit.
//  6 reset_n low during SHIFT -> an=FF, seg=7F, busy=0 same clk (async); recovers on release.

Source files
------------

// File: rtl/gh_display_pkg.sv
// Shared definitions for the score display path.
//  - Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//  - Converter state encoding
//  - Digit/anode counts and the nibble-to-segment decoder
package gh_display_pkg;

    localparam int NUM_BCD_DIGITS = 5;
    localparam int NUM_ANODES     = 8;
    localparam int BIN_W          = 16;
    localparam int BCD_W          = 4 * NUM_BCD_DIGITS;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_t;

    // Non-decimal nibbles cannot come out of the converter; show them dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
//  clk      in   system clock
//  reset_n  in   asynchronous active-low reset
//  start    in   request a conversion of bin; honoured only when idle
//  bin      in   16-bit unsigned value to convert
//  busy     out  high from the cycle after capture until the result is latched
//  done     out  high for the single LATCH cycle; bcd/bin_cap are valid then
//  bcd      out  20-bit packed BCD result (digit 0 in bits 3:0)
//  bin_cap  out  binary value that produced the current conversion
module bin2bcd_seq
    import gh_display_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic [BIN_W-1:0] bin_cap
);

    conv_state_t      state_reg, state_next;
    logic [BIN_W-1:0] bin_sr_reg, bin_sr_next;
    logic [BCD_W-1:0] bcd_sr_reg, bcd_sr_next;
    logic [BIN_W-1:0] cap_reg, cap_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             busy_reg, busy_next;
    logic [BCD_W-1:0] bcd_adj;

    // Add-3 correction per digit; digits never exceed 9, so no carry crosses nibbles.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_sr_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_sr_reg[4*gi +: 4] + 4'd3
                                      : bcd_sr_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        bin_sr_next = bin_sr_reg;
        bcd_sr_next = bcd_sr_reg;
        cap_next    = cap_reg;
        cnt_next    = cnt_reg;
        busy_next   = busy_reg;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_sr_next = bin;
                    cap_next    = bin;
                    bcd_sr_next = '0;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_sr_next, bin_sr_next} = {bcd_adj, bin_sr_reg} << 1;
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                done       = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            bin_sr_reg <= '0;
            bcd_sr_reg <= '0;
            cap_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bin_sr_reg <= bin_sr_next;
            bcd_sr_reg <= bcd_sr_next;
            cap_reg    <= cap_next;
            cnt_reg    <= cnt_next;
            busy_reg   <= busy_next;
        end
    end

    assign busy    = busy_reg;
    assign bcd     = bcd_sr_reg;
    assign bin_cap = cap_reg;

endmodule

// File: rtl/score_display.sv
// Score to 8-digit multiplexed seven-segment display driver.
// Converts the binary score to BCD whenever it changes, then scans the five
// score digits across the anodes with optional leading-zero blanking.
//  clk      in   system clock
//  reset_n  in   asynchronous active-low reset
//  score    in   16-bit unsigned score
//  an       out  active-low digit anodes, at most one low
//  seg      out  active-low cathodes {g,f,e,d,c,b,a}
//  dp       out  active-low decimal point, always off
//  busy     out  conversion in flight
module score_display
    import gh_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BIN_W-1:0]      score,
    output logic [NUM_ANODES-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [BIN_W-1:0]      last_score_reg;
    logic [BCD_W-1:0]      disp_bcd_reg;
    logic [CNT_W-1:0]      refresh_cnt_reg;
    logic [2:0]            scan_idx_reg;
    logic [NUM_ANODES-1:0] an_reg, an_next;
    logic [6:0]            seg_reg, seg_next;

    logic                  conv_start;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic [BIN_W-1:0]      conv_bin;

    // Requests raised while the converter is busy are simply held until it
    // returns to idle, so the display always converges on the latest score.
    assign conv_start = (score != last_score_reg);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (score),
        .busy    (busy),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .bin_cap (conv_bin)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_score_reg <= '0;
            disp_bcd_reg   <= '0;
        end else if (conv_done) begin
            last_score_reg <= conv_bin;
            disp_bcd_reg   <= conv_bcd;
        end
    end

    // A digit is lit if it or any more-significant digit is nonzero; digit 0 always lit.
    logic [NUM_BCD_DIGITS-1:0] digit_nz, digit_lit;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BCD_DIGITS; gi++) begin : g_blank
            assign digit_nz[gi] = |disp_bcd_reg[4*gi +: 4];
            if (gi == 0 || !BLANK_LEADING) begin : g_always
                assign digit_lit[gi] = 1'b1;
            end else begin : g_lead
                assign digit_lit[gi] = |digit_nz[NUM_BCD_DIGITS-1:gi];
            end
        end
    endgenerate

    always_comb begin
        an_next  = '1;
        seg_next = SEG_OFF;
        if (scan_idx_reg < 3'(NUM_BCD_DIGITS)) begin
            if (digit_lit[scan_idx_reg]) begin
                an_next[scan_idx_reg] = 1'b0;
                seg_next = seg_decode(disp_bcd_reg[4*scan_idx_reg +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt_reg <= '0;
            scan_idx_reg    <= '0;
            an_reg          <= '1;
            seg_reg         <= SEG_OFF;
        end else begin
            if (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt_reg <= '0;
                scan_idx_reg    <= scan_idx_reg + 3'd1;
            end else begin
                refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] score = 16'd0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int edges  = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .score   (score),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .busy    (busy)
    );

    // Clock edges since reset release: the scan model is derived from this.
    always @(posedge clk) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int pow10(input int i);
        int r;
        r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_score(input int v);
        score = 16'(v);
        exp_q.push_back(to_bcd(v));
        $display("drive score=%0d expect disp_bcd=%05h", v, to_bcd(v));
    endtask

    // Waits (bounded) for a conversion to finish and scores its latched result.
    task automatic wait_done(input string tag);
        bit saw;
        bit fin;
        logic [19:0] e;
        saw = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 60 && !fin; i++) begin
            tick();
            if (busy) saw = 1'b1;
            else if (saw) fin = 1'b1;
        end
        checks++;
        if (!fin) begin
            $display("FAIL %s: conversion timeout, busy=%b", tag, busy);
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s: result with empty scoreboard, got %05h", tag, dut.disp_bcd_reg);
        end else begin
            e = exp_q.pop_front();
            if (dut.disp_bcd_reg !== e)
                $display("FAIL %s: disp_bcd got %05h expected %05h", tag, dut.disp_bcd_reg, e);
            else begin
                passed++;
                $display("conv %s: disp_bcd=%05h", tag, e);
            end
        end
    endtask

    // Compares an/seg against a slot model for ncyc cycles; value must be settled.
    task automatic check_scan(input int value, input int ncyc, input string tag);
        int n, slot, zeros, bad_disp, bad_hot;
        logic [7:0] ea;
        logic [6:0] es;
        bad_disp = 0;
        bad_hot  = 0;
        tick();
        for (int c = 0; c < ncyc; c++) begin
            tick();
            n    = edges;
            slot = ((n - 1) / 4) % 8;
            ea   = 8'hFF;
            es   = 7'h7F;
            if (slot < 5 && (slot == 0 || value >= pow10(slot))) begin
                ea[slot] = 1'b0;
                es = seg_of((value / pow10(slot)) % 10);
            end
            checks++;
            if (an !== ea || seg !== es) begin
                $display("FAIL %s slot%0d: an=%h seg=%b expected an=%h seg=%b", tag, slot, an, seg, ea, es);
                bad_disp++;
            end else passed++;
            zeros = 0;
            for (int b = 0; b < 8; b++) if (an[b] === 1'b0) zeros++;
            checks++;
            if (zeros > 1) begin
                $display("FAIL %s onehot: an=%b has %0d low bits, at most 1 allowed", tag, an, zeros);
                bad_hot++;
            end else passed++;
        end
        $display("scan %s value=%0d cycles=%0d display_errs=%0d", tag, value, ncyc, bad_disp + bad_hot);
    endtask

    task automatic test_reset();
        bit bad;
        reset_n = 1'b0;
        score   = 16'd0;
        repeat (2) tick();
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_state: an=%h seg=%h dp=%b busy=%b expected FF 7F 1 0", an, seg, dp, busy);
        else passed++;
        reset_n = 1'b1;
        tick();
        checks++;
        if (an !== 8'hFE || seg !== 7'b1000000)
            $display("FAIL reset_slot0: an=%h seg=%b expected an=FE seg=1000000", an, seg);
        else passed++;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL reset_idle_busy: busy rose with score=0, expected 0");
        else passed++;
        $display("reset test done");
    endtask

    task automatic test_convert_1234();
        logic [19:0] e;
        drive_score(1234);
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (busy !== 1'b1) $display("FAIL busy_window clk%0d: busy=%b expected 1", k, busy);
            else passed++;
        end
        checks++;
        if (dut.disp_bcd_reg !== 20'h0)
            $display("FAIL early_latch: disp_bcd=%05h expected 00000 at clk17", dut.disp_bcd_reg);
        else passed++;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (busy !== 1'b0 || dut.disp_bcd_reg !== e)
            $display("FAIL latency18: busy=%b disp_bcd=%05h expected busy=0 disp_bcd=%05h", busy, dut.disp_bcd_reg, e);
        else passed++;
        $display("conv 1234 latency: disp_bcd=%05h", e);
        check_scan(1234, 40, "s1234");
    endtask

    task automatic test_full_scale();
        drive_score(65535);
        wait_done("c65535");
        check_scan(65535, 40, "s65535");
    endtask

    task automatic test_blanking();
        drive_score(9);
        wait_done("c9");
        check_scan(9, 36, "s9");
        drive_score(10005);
        wait_done("c10005");
        check_scan(10005, 36, "s10005");
    endtask

    task automatic test_back_to_back();
        bit bad;
        drive_score(100);
        repeat (5) tick();
        drive_score(200);
        wait_done("b2b_first");
        wait_done("b2b_second");
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || dut.disp_bcd_reg !== 20'h00200)
            $display("FAIL b2b_settle: busy_seen=%b disp_bcd=%05h expected busy 0 disp 00200", bad, dut.disp_bcd_reg);
        else passed++;
        check_scan(200, 12, "s200");
    endtask

    task automatic test_reset_mid();
        score = 16'd500;
        $display("drive score=500 then reset during conversion");
        repeat (6) tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b expected 1 before reset", busy);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || busy !== 1'b0)
            $display("FAIL async_reset: an=%h seg=%h busy=%b expected FF 7F 0", an, seg, busy);
        else passed++;
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.push_back(to_bcd(500));
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL restart: busy=%b expected 1 on first clk after release", busy);
        else passed++;
        wait_done("c500_after_reset");
        check_scan(500, 36, "s500");
    endtask

    initial begin
        test_reset();
        test_convert_1234();
        test_full_scale();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
